// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_ctrl (with embedded alu4)
//  Description : Sequencing controller around a 4-bit combinational ALU and
//                a small register file. It accepts reg-reg or reg-imm
//                instructions, executes them, writes the result back and
//                returns the result and flags over valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// 4-bit combinational ALU: ADD/SUB/AND/OR/XOR/SLT. Any other opcode produces
// a zero result, which sets the zero flag and leaves the SLT flag clear.
// ----------------------------------------------------------------------------
module alu4 (
    input  logic [2:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] result,
    output logic       zero_flag,
    output logic       slt_flag
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SLT = 3'b101;

    // Result and flags. ADD and SUB wrap at 4 bits; SLT is a signed compare.
    always_comb begin
        result   = 4'd0;
        slt_flag = 1'b0;
        case (op)
            c_OP_ADD: result = a + b;
            c_OP_SUB: result = a - b;
            c_OP_AND: result = a & b;
            c_OP_OR:  result = a | b;
            c_OP_XOR: result = a ^ b;
            c_OP_SLT: begin
                slt_flag = ($signed(a) < $signed(b));
                result   = {3'b000, slt_flag};
            end
            default:  result = 4'd0;
        endcase
        zero_flag = (result == 4'd0);
    end

endmodule

// ----------------------------------------------------------------------------
// Controller: IDLE accepts an instruction and captures its operands, EXEC
// latches the ALU outputs and writes back, and RESP holds the response until
// the consumer takes it.
// ----------------------------------------------------------------------------
module alu_seq_ctrl #(
    parameter int REG_ADDR_W = 2,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [2:0]            instr_op,
    input  logic [REG_ADDR_W-1:0] instr_rd,
    input  logic [REG_ADDR_W-1:0] instr_rs1,
    input  logic [REG_ADDR_W-1:0] instr_rs2,
    input  logic                  instr_imm_sel,
    input  logic [3:0]            instr_imm,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [3:0]            res_data,
    output logic                  res_zero,
    output logic                  res_slt,
    output logic                  res_err,
    output logic [REG_ADDR_W-1:0] res_rd,
    output logic                  err_sticky,
    input  logic                  clr_err,
    output logic [CNT_W-1:0]      op_count,
    output logic                  busy,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [3:0]            dbg_data
);

    localparam int          c_NREGS   = 1 << REG_ADDR_W;
    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_EXEC    = 2'd1;
    localparam logic [1:0]  c_RESP    = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [3:0]            r_regs [0:c_NREGS-1];

    logic [2:0]            r_op;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_err;
    logic [3:0]            r_a;
    logic [3:0]            r_b;

    logic [3:0]            r_res_data;
    logic                  r_res_zero;
    logic                  r_res_slt;
    logic                  r_res_err;
    logic [REG_ADDR_W-1:0] r_res_rd;
    logic                  r_err_sticky;
    logic [CNT_W-1:0]      r_op_count;

    logic [3:0]            w_alu_result;
    logic                  w_alu_zero;
    logic                  w_alu_slt;
    logic                  w_accept;
    logic                  w_exec_done;
    logic                  w_resp_done;

    alu4 u_alu (
        .op        (r_op),
        .a         (r_a),
        .b         (r_b),
        .result    (w_alu_result),
        .zero_flag (w_alu_zero),
        .slt_flag  (w_alu_slt)
    );

    assign w_accept    = (r_state == c_IDLE) && instr_valid;
    assign w_exec_done = (r_state == c_EXEC);
    assign w_resp_done = (r_state == c_RESP) && res_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state: one cycle in EXEC, RESP waits for the consumer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (instr_valid) w_next_state = c_EXEC;
            c_EXEC:  w_next_state = c_RESP;
            c_RESP:  if (res_ready) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        instr_ready = (r_state == c_IDLE);
        res_valid   = (r_state == c_RESP);
        busy        = (r_state != c_IDLE);
    end

    // Capture opcode, destination and both operands at the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op  <= 3'd0;
            r_rd  <= '0;
            r_err <= 1'b0;
            r_a   <= 4'd0;
            r_b   <= 4'd0;
        end else if (w_accept) begin
            r_op  <= instr_op;
            r_rd  <= instr_rd;
            r_err <= (instr_op > 3'b101);
            r_a   <= r_regs[instr_rs1];
            r_b   <= instr_imm_sel ? instr_imm : r_regs[instr_rs2];
        end
    end

    // Register file; written at the end of EXEC unless the opcode was illegal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NREGS; i++) r_regs[i] <= 4'd0;
        end else if (w_exec_done && !r_err) begin
            r_regs[r_rd] <= w_alu_result;
        end
    end

    // Response registers, loaded at the end of EXEC and held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_data <= 4'd0;
            r_res_zero <= 1'b0;
            r_res_slt  <= 1'b0;
            r_res_err  <= 1'b0;
            r_res_rd   <= '0;
        end else if (w_exec_done) begin
            r_res_data <= w_alu_result;
            r_res_zero <= w_alu_zero;
            r_res_slt  <= w_alu_slt;
            r_res_err  <= r_err;
            r_res_rd   <= r_rd;
        end
    end

    // Sticky error: an illegal opcode setting it has priority over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      r_err_sticky <= 1'b0;
        else if (w_exec_done && r_err) r_err_sticky <= 1'b1;
        else if (clr_err)             r_err_sticky <= 1'b0;
    end

    // Completed-response counter, saturating at all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (w_resp_done && (r_op_count != c_CNT_MAX)) begin
            r_op_count <= r_op_count + c_CNT_ONE;
        end
    end

    assign res_data   = r_res_data;
    assign res_zero   = r_res_zero;
    assign res_slt    = r_res_slt;
    assign res_err    = r_res_err;
    assign res_rd     = r_res_rd;
    assign err_sticky = r_err_sticky;
    assign op_count   = r_op_count;
    assign dbg_data   = r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_ctrl
//  Description : Self-checking bench for alu_seq_ctrl using directed and
//                random instructions against a behavioural register model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

    localparam int c_AW    = 2;
    localparam int c_CW    = 2;
    localparam int c_CMAX  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            instr_valid = 1'b0;
    logic            instr_ready;
    logic [2:0]      instr_op = 3'd0;
    logic [c_AW-1:0] instr_rd = '0;
    logic [c_AW-1:0] instr_rs1 = '0;
    logic [c_AW-1:0] instr_rs2 = '0;
    logic            instr_imm_sel = 1'b0;
    logic [3:0]      instr_imm = 4'd0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [3:0]      res_data;
    logic            res_zero;
    logic            res_slt;
    logic            res_err;
    logic [c_AW-1:0] res_rd;
    logic            err_sticky;
    logic            clr_err = 1'b0;
    logic [c_CW-1:0] op_count;
    logic            busy;
    logic [c_AW-1:0] dbg_addr = '0;
    logic [3:0]      dbg_data;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    int m_regs [4];
    int m_count;
    int m_sticky;

    alu_seq_ctrl #(.REG_ADDR_W(c_AW), .CNT_W(c_CW)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
        .instr_rs2(instr_rs2), .instr_imm_sel(instr_imm_sel), .instr_imm(instr_imm),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_zero(res_zero), .res_slt(res_slt), .res_err(res_err), .res_rd(res_rd),
        .err_sticky(err_sticky), .clr_err(clr_err), .op_count(op_count),
        .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Reference ALU from plain integer arithmetic: returns {result, zero, slt}.
    function automatic logic [5:0] ref_alu(input int op, input int a, input int b);
        int r, sa, sb, s;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        s  = 0;
        case (op)
            0: r = (a + b) % 16;
            1: r = (a - b + 16) % 16;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin s = (sa < sb) ? 1 : 0; r = s; end
            default: r = 0;
        endcase
        ref_alu = {r[3:0], (r == 0), s[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_count  = 0;
        m_sticky = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // One instruction end to end; 'hold' cycles of backpressure in RESP.
    task automatic do_instr(input int op, input int rd, input int rs1, input int rs2,
                            input int isel, input int imm, input int hold, input int clr);
        int a, b, err, waited;
        logic [5:0] exp;
        logic [9:0] exp_resp, got_resp;
        a   = m_regs[rs1];
        b   = isel ? imm : m_regs[rs2];
        exp = ref_alu(op, a, b);
        err = (op > 5) ? 1 : 0;

        n_checks++;
        if (instr_ready !== 1'b1) begin
            n_errors++; $display("FAIL idle_ready: got %b want 1", instr_ready);
        end
        instr_valid   = 1'b1;
        instr_op      = op[2:0];
        instr_rd      = rd[1:0];
        instr_rs1     = rs1[1:0];
        instr_rs2     = rs2[1:0];
        instr_imm_sel = isel[0];
        instr_imm     = imm[3:0];
        res_ready     = 1'($urandom_range(0, 1));
        step();
        instr_valid = 1'b0;
        {instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm_sel, instr_imm} = 14'($urandom);
        n_checks++;
        if ({instr_ready, res_valid, busy} !== 3'b001) begin
            n_errors++; $display("FAIL exec_status: got rdy/vld/busy %b want 001", {instr_ready, res_valid, busy});
        end
        clr_err = clr[0];
        step();
        clr_err   = 1'b0;
        res_ready = (hold == 0);
        if (!err) m_regs[rd] = int'(exp[5:2]);
        m_sticky = err ? 1 : (clr ? 0 : m_sticky);

        n_checks++;
        if (res_valid !== 1'b1) begin
            n_errors++; $display("FAIL resp_latency: res_valid %b want 1 two cycles after accept", res_valid);
            waited = 0;
            while (res_valid !== 1'b1 && waited < 10) begin step(); waited++; end
        end
        exp_resp = {exp[5:2], exp[1], exp[0], err[0], 1'b1, rd[1:0]};
        for (int h = 0; h <= hold; h++) begin
            dbg_addr = rd[1:0];
            #1;
            got_resp = {res_data, res_zero, res_slt, res_err, res_valid, res_rd};
            n_checks++;
            if (got_resp !== exp_resp) begin
                n_errors++; $display("FAIL resp_fields: got data/z/slt/err/vld/rd %h want %h (op %0d a %0d b %0d)",
                                     got_resp, exp_resp, op, a, b);
            end
            n_checks++;
            if ({instr_ready, err_sticky, dbg_data} !== {1'b0, m_sticky[0], 4'(m_regs[rd])}) begin
                n_errors++; $display("FAIL resp_state: got rdy/sticky/reg %b/%b/%h want 0/%0d/%h",
                                     instr_ready, err_sticky, dbg_data, m_sticky, m_regs[rd]);
            end
            if (h < hold) step();
            if (h == hold - 1) res_ready = 1'b1;
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        if (m_count < c_CMAX) m_count++;
        n_checks++;
        if ({instr_ready, res_valid, busy, op_count} !== {3'b100, 2'(m_count)}) begin
            n_errors++; $display("FAIL after_handshake: got rdy/vld/busy %b cnt %0d want 100 cnt %0d",
                                 {instr_ready, res_valid, busy}, op_count, m_count);
        end
    endtask

    task automatic check_reset_state(input string tag);
        n_checks++;
        if ({instr_ready, res_valid, busy, op_count, err_sticky, res_data, res_zero, res_slt, res_err, res_rd}
            !== {3'b100, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            n_errors++; $display("FAIL %s: rdy/vld/busy %b cnt %0d sticky %b data %h z %b slt %b err %b rd %0d want all idle/zero",
                                 tag, {instr_ready, res_valid, busy}, op_count, err_sticky, res_data,
                                 res_zero, res_slt, res_err, res_rd);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = i[1:0];
            #1;
            n_checks++;
            if (dbg_data !== 4'd0) begin
                n_errors++; $display("FAIL %s_reg%0d: got %h want 0", tag, i, dbg_data);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        model_reset();
        check_reset_state("reset");
        rst = 1'b0;
        step();
    endtask

    task automatic test_add_chain();
        do_instr(0, 1, 0, 0, 1, 5, 0, 0);   // reg1 = 0 + 5
        do_instr(0, 2, 1, 0, 1, 3, 0, 0);   // reg2 = 5 + 3
    endtask

    task automatic test_backpressure();
        do_instr(1, 3, 2, 0, 1, 8, 5, 0);   // reg3 = 8 - 8, held 5 cycles
    endtask

    task automatic test_slt();
        do_instr(5, 3, 1, 0, 1, 8, 0, 0);   // 5 < -8 ? no
        do_instr(5, 3, 2, 0, 1, 5, 1, 0);   // -8 < 5 ? yes
    endtask

    task automatic test_illegal();
        do_instr(6, 1, 0, 0, 1, 7, 0, 0);   // illegal, reg1 keeps 5
        do_instr(7, 2, 0, 0, 0, 0, 0, 1);   // clr on the same edge as the set
        clr_err = 1'b1;
        step();
        clr_err  = 1'b0;
        m_sticky = 0;
        n_checks++;
        if (err_sticky !== 1'b0) begin
            n_errors++; $display("FAIL clr_err: got %b want 0", err_sticky);
        end
    endtask

    task automatic test_random(input int n);
        for (int k = 0; k < n; k++)
            do_instr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 15),
                     $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? 1 : 0);
    endtask

    task automatic test_reset_mid_exec();
        do_instr(0, 0, 1, 0, 1, 9, 0, 0);   // make sure some state is non-zero
        instr_valid = 1'b1; instr_op = 3'd0; instr_rd = 2'd0;
        instr_rs1 = 2'd1; instr_imm_sel = 1'b1; instr_imm = 4'd3;
        step();
        instr_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_reset_state("mid_reset");
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++)
            do_instr(4, k % 4, (k + 1) % 4, (k + 2) % 4, k % 2, k * 3 + 1, 0, 0);
        n_checks++;
        if (op_count !== 2'(c_CMAX)) begin
            n_errors++; $display("FAIL saturation: got %0d want %0d", op_count, c_CMAX);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add_chain();
        test_backpressure();
        test_slt();
        test_illegal();
        test_random(40);
        test_reset_mid_exec();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
